// File: rtl/bcd_display_ctrl.sv
// Sequenced binary-to-BCD converter (double-dabble) driving three held
// 7-segment digits with optional leading-zero blanking.
module bcd_display_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2
);

  localparam int SRW = 12 + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SRW-1:0]  r_sr;
  logic [SRW-1:0]  w_adj;
  logic [CW-1:0]   r_cnt;
  logic [11:0]     r_bcd;
  logic            r_done;
  logic            w_h_blank;
  logic            w_t_blank;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(WIDTH - 1)) w_next = LOAD;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction on each BCD nibble; the shift happens in the register.
  always_comb begin
    w_adj = r_sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_sr[WIDTH + 4*i +: 4] >= 4'd5)
        w_adj[WIDTH + 4*i +: 4] = r_sr[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr  <= {12'd0, bin};
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_sr  <= w_adj << 1;
          r_cnt <= r_cnt + CW'(1);
        end
        LOAD: begin
          r_bcd  <= r_sr[SRW-1:WIDTH];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign w_h_blank = blank_lz && (r_bcd[11:8] == 4'd0);
  assign w_t_blank = w_h_blank && (r_bcd[7:4] == 4'd0);

  assign HEX0 = seg7(r_bcd[3:0]);
  assign HEX1 = w_t_blank ? '0 : seg7(r_bcd[7:4]);
  assign HEX2 = w_h_blank ? '0 : seg7(r_bcd[11:8]);

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: directed scenarios plus random
// conversions checked against an arithmetic decimal/segment model.
module tb_bcd_display_ctrl;

  localparam int W     = 8;
  localparam int LIMIT = 4*W + 10;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         start;
  logic [W-1:0] bin;
  logic         blank_lz;
  logic         busy;
  logic         done;
  logic [11:0]  bcd;
  logic [6:0]   HEX0, HEX1, HEX2;

  int n_checks = 0;
  int n_fail   = 0;
  int shown    = 0;

  logic [6:0] SEG [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111};

  bcd_display_ctrl #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .bin      (bin),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input int v, input string tag);
    int h, t, u;
    logic [6:0] e2, e1;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    e2 = (blank_lz && h == 0) ? 7'b0 : SEG[h];
    e1 = (blank_lz && h == 0 && t == 0) ? 7'b0 : SEG[t];
    chk({tag, ".bcd"},  32'(bcd),  32'(h*256 + t*16 + u));
    chk({tag, ".hex0"}, 32'(HEX0), 32'(SEG[u]));
    chk({tag, ".hex1"}, 32'(HEX1), 32'(e1));
    chk({tag, ".hex2"}, 32'(HEX2), 32'(e2));
  endtask

  // Called at a negedge with the block idle; returns at the negedge after acceptance.
  task automatic launch(input int v);
    start = 1'b1;
    bin   = W'(v);
    @(negedge Clock);
    start = 1'b0;
    chk("accept.done_low", 32'(done), 32'd0);
  endtask

  // Waits for done, optionally throwing ignored start pulses and bin changes.
  task automatic finish_conv(input int v, input bit junk, input string tag);
    int e = 0, nbusy = 0;
    bit held = 1'b1;
    while (done !== 1'b1 && e < LIMIT) begin
      if (busy === 1'b1) nbusy++;
      if (32'(bcd) !== 32'(shown[11:0])) held = 1'b0;
      if (junk) begin
        start = (e % 3 == 1);
        bin   = (e == 3) ? W'(7) : W'($urandom);
      end
      @(negedge Clock);
      e++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(e), 32'(W + 1));
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(W + 1));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".held"}, 32'(held), 32'd1);
    chk_disp(v, tag);
    shown = (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endtask

  initial begin
    int v;
    Resetn   = 1'b0;
    start    = 1'b0;
    bin      = '0;
    blank_lz = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_disp(0, "rst");
    Resetn = 1'b1;
    @(negedge Clock);

    launch(255);
    finish_conv(255, 1'b0, "c255");
    @(negedge Clock);
    chk("c255.done_clears", 32'(done), 32'd0);

    blank_lz = 1'b1;
    launch(13);
    finish_conv(13, 1'b0, "c13");
    blank_lz = 1'b0;
    #1;
    chk("c13.unblank_hex2", 32'(HEX2), 32'(7'b0111111));
    chk("c13.unblank_hex1", 32'(HEX1), 32'(7'b0000110));
    @(negedge Clock);

    launch(200);
    finish_conv(200, 1'b1, "c200");
    launch(7);
    finish_conv(7, 1'b0, "c7");
    @(negedge Clock);

    launch(99);
    finish_conv(99, 1'b0, "c99");
    launch(100);
    repeat (4) @(negedge Clock);
    chk("abort.hold", 32'(bcd), 32'h099);
    Resetn = 1'b0;
    #1;
    chk("abort.bcd", 32'(bcd), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk_disp(0, "abort");
    shown = 0;
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge Clock);
      chk("abort.no_done", 32'(done), 32'd0);
    end
    launch(100);
    finish_conv(100, 1'b0, "c100");

    // Back-to-back sweep: each start is issued in the done cycle of the previous one.
    for (int i = 0; i < (1 << W); i++) begin
      blank_lz = 1'($urandom);
      launch(i);
      finish_conv(i, 1'b0, "sweep");
    end
    @(negedge Clock);

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      blank_lz = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      launch(v);
      finish_conv(v, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
